// File: rtl/accumulator_unit.sv
// Datapath accumulator: LOAD/ADD/SUB/SHL/CLR with flags,
// optional signed saturation and a small PUSH/POP save stack.
module accumulator_unit #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SAT_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             opValid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] accOut,
  output logic             carryFlag,
  output logic             ovfFlag,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             stackFull,
  output logic             stackEmpty,
  output logic             stackErr
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_CLR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             ovf;
  logic [PW-1:0]    ptr;
  logic             err;
  logic [WIDTH-1:0] stack [DEPTH];

  logic [WIDTH-1:0] acc_d;
  logic             carry_d;
  logic             ovf_d;
  logic [PW-1:0]    ptr_d;
  logic             err_d;
  logic             push_en;

  op_e              opc;
  logic [WIDTH:0]   add_raw;
  logic [WIDTH:0]   sub_raw;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] smax;
  logic [WIDTH-1:0] smin;
  logic [WIDTH-1:0] sat_val;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic             full;
  logic             empty;

  assign opc     = op_e'(op);
  assign add_raw = {1'b0, acc} + {1'b0, dataIn};
  assign sub_raw = {1'b0, acc} - {1'b0, dataIn};

  assign add_ovf = (acc[WIDTH-1] == dataIn[WIDTH-1]) &&
                   (add_raw[WIDTH-1] != acc[WIDTH-1]);
  assign sub_ovf = (acc[WIDTH-1] != dataIn[WIDTH-1]) &&
                   (sub_raw[WIDTH-1] != acc[WIDTH-1]);

  // On signed overflow the true result has the sign of acc
  assign smax    = {1'b0, {(WIDTH-1){1'b1}}};
  assign smin    = {1'b1, {(WIDTH-1){1'b0}}};
  assign sat_val = acc[WIDTH-1] ? smin : smax;

  assign push_idx = AW'(ptr);
  assign pop_idx  = AW'(ptr - PW'(1));
  assign full     = (ptr == PW'(DEPTH));
  assign empty    = (ptr == '0);

  always_comb begin
    acc_d   = acc;
    carry_d = carry;
    ovf_d   = ovf;
    ptr_d   = ptr;
    err_d   = 1'b0;
    push_en = 1'b0;
    if (opValid) begin
      unique case (opc)
        OP_NOP: ;
        OP_LOAD: begin
          acc_d   = dataIn;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_ADD: begin
          carry_d = add_raw[WIDTH];
          ovf_d   = add_ovf;
          if (SAT_EN != 0 && add_ovf)
            acc_d = sat_val;
          else
            acc_d = add_raw[WIDTH-1:0];
        end
        OP_SUB: begin
          carry_d = sub_raw[WIDTH];
          ovf_d   = sub_ovf;
          if (SAT_EN != 0 && sub_ovf)
            acc_d = sat_val;
          else
            acc_d = sub_raw[WIDTH-1:0];
        end
        OP_CLR: begin
          acc_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_SHL: begin
          acc_d   = {acc[WIDTH-2:0], 1'b0};
          carry_d = acc[WIDTH-1];
          ovf_d   = acc[WIDTH-1] ^ acc[WIDTH-2];
        end
        OP_PUSH: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            ptr_d   = ptr + PW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            acc_d   = stack[pop_idx];
            ptr_d   = ptr - PW'(1);
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      ptr   <= '0;
      err   <= 1'b0;
    end else begin
      acc   <= acc_d;
      carry <= carry_d;
      ovf   <= ovf_d;
      ptr   <= ptr_d;
      err   <= err_d;
    end
  end

  // Stack storage needs no reset; ptr alone defines validity
  always_ff @(posedge clk) begin
    if (push_en)
      stack[push_idx] <= acc;
  end

  assign accOut     = acc;
  assign carryFlag  = carry;
  assign ovfFlag    = ovf;
  assign zeroFlag   = (acc == '0);
  assign negFlag    = acc[WIDTH-1];
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign stackErr   = err;

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed bench for accumulator_unit: wrap and saturating
// instances driven in lockstep, checked against hand values.
module tb_accumulator_unit;

  logic       clk;
  logic       rst;
  logic       opValid;
  logic [2:0] op;
  logic [7:0] dataIn;

  logic [7:0] acc0, acc1;
  logic c0, v0, z0, n0, f0, e0, x0;
  logic c1, v1, z1, n1, f1, e1, x1;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] SUB  = 3'b011;
  localparam logic [2:0] CLR  = 3'b100;
  localparam logic [2:0] SHL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  accumulator_unit #(.WIDTH(8), .DEPTH(4), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .opValid(opValid), .op(op),
    .dataIn(dataIn), .accOut(acc0), .carryFlag(c0),
    .ovfFlag(v0), .zeroFlag(z0), .negFlag(n0),
    .stackFull(f0), .stackEmpty(e0), .stackErr(x0)
  );

  accumulator_unit #(.WIDTH(8), .DEPTH(4), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .opValid(opValid), .op(op),
    .dataIn(dataIn), .accOut(acc1), .carryFlag(c1),
    .ovfFlag(v1), .zeroFlag(z1), .negFlag(n1),
    .stackFull(f1), .stackEmpty(e1), .stackErr(x1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One op per call; outputs are stable 1 ns after the edge
  task automatic run(input logic [2:0] o, input logic [7:0] d);
    @(negedge clk);
    opValid = 1'b1;
    op      = o;
    dataIn  = d;
    @(posedge clk);
    #1;
    opValid = 1'b0;
    op      = NOP;
  endtask

  task automatic idle();
    @(negedge clk);
    opValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pops [4];

  initial begin
    rst     = 1'b1;
    opValid = 1'b0;
    op      = NOP;
    dataIn  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",   acc0, 8'h00);
    check("rst_carry", c0, 1'b0);
    check("rst_ovf",   v0, 1'b0);
    check("rst_empty", e0, 1'b1);
    check("rst_full",  f0, 1'b0);
    check("rst_err",   x0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset with live state, observed without a clock edge
    run(LOAD, 8'h5A);
    run(PUSH, 8'h00);
    run(PUSH, 8'h00);
    check("pre_rst_acc", acc0, 8'h5A);
    check("pre_rst_emp", e0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_acc",  acc0, 8'h00);
    check("async_zero", z0, 1'b1);
    check("async_emp",  e0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    run(LOAD, 8'h7F);
    run(ADD,  8'h01);
    check("add_ovf_acc",   acc0, 8'h80);
    check("add_ovf_v",     v0, 1'b1);
    check("add_ovf_c",     c0, 1'b0);
    check("add_ovf_n",     n0, 1'b1);
    check("sat_acc",       acc1, 8'h7F);
    check("sat_v",         v1, 1'b1);
    check("sat_c",         c1, 1'b0);

    run(LOAD, 8'h80);
    run(SUB,  8'h01);
    check("sub_ovf_acc", acc0, 8'h7F);
    check("sub_ovf_v",   v0, 1'b1);
    check("sub_sat_acc", acc1, 8'h80);

    run(LOAD, 8'h10);
    run(SUB,  8'h20);
    check("sub_acc", acc0, 8'hF0);
    check("sub_c",   c0, 1'b1);
    check("sub_v",   v0, 1'b0);
    check("sub_n",   n0, 1'b1);

    run(LOAD, 8'hFF);
    run(ADD,  8'h01);
    check("add_wrap_acc", acc0, 8'h00);
    check("add_wrap_c",   c0, 1'b1);
    check("add_wrap_z",   z0, 1'b1);
    check("add_wrap_v",   v0, 1'b0);

    run(LOAD, 8'hC0);
    run(SHL,  8'h00);
    check("shl1_acc", acc0, 8'h80);
    check("shl1_c",   c0, 1'b1);
    check("shl1_v",   v0, 1'b0);
    run(SHL,  8'h00);
    check("shl2_acc", acc0, 8'h00);
    check("shl2_c",   c0, 1'b1);
    check("shl2_v",   v0, 1'b1);
    check("shl2_z",   z0, 1'b1);

    run(LOAD, 8'h33);
    run(CLR,  8'h00);
    check("clr_acc", acc0, 8'h00);
    check("clr_c",   c0, 1'b0);

    run(LOAD, 8'h11); run(PUSH, 8'h00);
    run(LOAD, 8'h22); run(PUSH, 8'h00);
    run(LOAD, 8'h33); run(PUSH, 8'h00);
    check("push3_full", f0, 1'b0);
    run(LOAD, 8'h44); run(PUSH, 8'h00);
    check("push4_full", f0, 1'b1);
    check("push4_err",  x0, 1'b0);
    run(PUSH, 8'h00);
    check("push5_err",  x0, 1'b1);
    check("push5_acc",  acc0, 8'h44);
    check("push5_full", f0, 1'b1);
    idle();
    check("push5_err_clr", x0, 1'b0);

    // Set carry so the POP clear is visible
    run(LOAD, 8'hFF);
    run(ADD,  8'h02);
    check("pre_pop_c", c0, 1'b1);

    pops[0] = 8'h44; pops[1] = 8'h33;
    pops[2] = 8'h22; pops[3] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      run(POP, 8'h00);
      check($sformatf("pop%0d_acc", i), acc0, pops[i]);
      check($sformatf("pop%0d_c", i), c0, 1'b0);
    end
    check("pop_empty", e0, 1'b1);
    check("pop_full",  f0, 1'b0);

    run(POP, 8'h00);
    check("pop_e_err", x0, 1'b1);
    check("pop_e_acc", acc0, 8'h11);
    check("pop_e_emp", e0, 1'b1);
    idle();
    check("pop_e_clr", x0, 1'b0);

    // Op presented without opValid must be ignored
    @(negedge clk);
    opValid = 1'b0;
    op      = LOAD;
    dataIn  = 8'h99;
    @(posedge clk);
    #1;
    check("novalid_acc", acc0, 8'h11);
    op = NOP;

    run(NOP, 8'hAA);
    check("nop_acc", acc0, 8'h11);
    check("nop_err", x0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
